// File: rtl/ubx_uart_rx.sv
// 8N1 UART receiver feeding the UBX parser: two-flop line synchroniser, mid-bit
// sampling, single-cycle byte strobes, framing-error strobe and saturating count.
module ubx_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic                 i_uart_clk,
    input  logic                 i_uart_rst,
    input  logic                 i_uart_rxd,
    output logic [7:0]           o_data_tdata,
    output logic                 o_data_tvalid,
    output logic                 o_frame_error,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic                 sync1, rx_s;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [7:0]           shreg, shreg_nxt;
    logic [7:0]           tdata_nxt;
    logic                 tvalid_nxt;
    logic                 ferr_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;

    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            o_data_tdata  <= '0;
            o_data_tvalid <= 1'b0;
            o_frame_error <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            sync1         <= i_uart_rxd;
            rx_s          <= sync1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            shreg         <= shreg_nxt;
            o_data_tdata  <= tdata_nxt;
            o_data_tvalid <= tvalid_nxt;
            o_frame_error <= ferr_nxt;
            o_err_cnt     <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        tdata_nxt   = o_data_tdata;
        tvalid_nxt  = 1'b0;
        ferr_nxt    = 1'b0;
        err_cnt_nxt = o_err_cnt;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                // A line back high at mid-start-bit is a glitch, not a frame.
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        tdata_nxt  = shreg;
                        tvalid_nxt = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                        if (o_err_cnt != '1) begin
                            err_cnt_nxt = o_err_cnt + 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // Hold here until the line recovers so a stuck-low line yields one error.
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ubx_uart_rx.sv
// Scoreboard bench for ubx_uart_rx at 16 clocks per bit with a 2-bit error counter.
module tb_ubx_uart_rx;

    localparam int unsigned CPB     = 16;
    localparam int unsigned H       = CPB / 2;
    localparam int unsigned ERR_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] o_data_tdata;
    logic       o_data_tvalid;
    logic       o_frame_error;
    logic [1:0] o_err_cnt;
    logic       o_busy;

    ubx_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .ERR_CNT_W   (2)
    ) dut (
        .i_uart_clk   (clk),
        .i_uart_rst   (rst),
        .i_uart_rxd   (rxd),
        .o_data_tdata (o_data_tdata),
        .o_data_tvalid(o_data_tvalid),
        .o_frame_error(o_frame_error),
        .o_err_cnt    (o_err_cnt),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_fe = 0;
    int         model_err = 0;
    logic [7:0] exp_data[$];
    int         exp_err[$];
    int         valid_cycles[$];
    logic [7:0] rx_log[$];

    // One clock: advance past the rising edge, then inspect outputs on the falling edge.
    task automatic tick();
        logic [7:0] e;
        int         ee;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (o_data_tvalid) begin
            n_valid++;
            valid_cycles.push_back(cyc);
            rx_log.push_back(o_data_tdata);
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tvalid got %02h expected none", o_data_tdata);
            end else begin
                e = exp_data.pop_front();
                if (o_data_tdata !== e) begin
                    errors++;
                    $display("FAIL tdata got %02h expected %02h", o_data_tdata, e);
                end
            end
        end
        if (o_frame_error) begin
            n_fe++;
            checks++;
            if (exp_err.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_error err_cnt %0d expected none", o_err_cnt);
            end else begin
                ee = exp_err.pop_front();
                if (o_err_cnt !== 2'(ee)) begin
                    errors++;
                    $display("FAIL err_cnt got %0d expected %0d", o_err_cnt, ee);
                end
            end
        end
    endtask

    task automatic hold_line(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_data.push_back(d);
        end else begin
            model_err = (model_err >= int'(ERR_MAX)) ? int'(ERR_MAX) : model_err + 1;
            exp_err.push_back(model_err);
        end
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            hold_line(d[i], CPB);
        end
        hold_line(stop, CPB);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_err = 0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_data.size() != 0 || exp_err.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got data=%0d err=%0d expected 0 0", name, exp_data.size(), exp_err.size());
        end
    endtask

    task automatic test_reset();
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_err = 0;
        checks++;
        if ({o_data_tdata, o_data_tvalid, o_frame_error, o_err_cnt, o_busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got td=%02h v=%b fe=%b ec=%0d busy=%b expected all 0",
                     o_data_tdata, o_data_tvalid, o_frame_error, o_err_cnt, o_busy);
        end
        hold_line(1'b1, 10);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b expected 0", o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int e_edge;
        valid_cycles.delete();
        e_edge = cyc + 1;
        send_byte(8'hB5, 1'b1);
        send_byte(8'h62, 1'b1);
        hold_line(1'b1, 2 * CPB);
        check_drained("b2b");
        checks++;
        if (valid_cycles.size() != 2) begin
            errors++;
            $display("FAIL b2b_strobes got %0d expected 2", valid_cycles.size());
        end else begin
            if (valid_cycles[0] != e_edge + 2 + int'(H) + 9 * int'(CPB)) begin
                errors++;
                $display("FAIL b2b_first_latency got %0d expected %0d", valid_cycles[0] - e_edge,
                         2 + int'(H) + 9 * int'(CPB));
            end
            checks++;
            if (valid_cycles[1] - valid_cycles[0] != 10 * int'(CPB)) begin
                errors++;
                $display("FAIL b2b_spacing got %0d expected %0d", valid_cycles[1] - valid_cycles[0],
                         10 * int'(CPB));
            end
        end
    endtask

    task automatic test_frame_error();
        int fe0;
        int v0;
        fe0 = n_fe;
        v0  = n_valid;
        send_byte(8'h55, 1'b0);
        hold_line(1'b0, 3 * CPB);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy got %b expected 1", o_busy);
        end
        hold_line(1'b1, 2 * CPB);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_exit_busy got %b expected 0", o_busy);
        end
        checks++;
        if (n_fe - fe0 != 1 || n_valid != v0) begin
            errors++;
            $display("FAIL frame_error_counts got fe=%0d valid=%0d expected 1 0", n_fe - fe0, n_valid - v0);
        end
        send_byte(8'hA3, 1'b1);
        hold_line(1'b1, 2 * CPB);
        check_drained("frame_error");
        checks++;
        if (o_err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL err_cnt_hold got %0d expected 1", o_err_cnt);
        end
    endtask

    task automatic test_glitch();
        int fe0;
        int v0;
        int busy_cycles;
        fe0 = n_fe;
        v0  = n_valid;
        busy_cycles = 0;
        rxd = 1'b0;
        repeat (5) begin
            tick();
            if (o_busy) busy_cycles++;
        end
        rxd = 1'b1;
        repeat (30) begin
            tick();
            if (o_busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles < 1 || busy_cycles > int'(H)) begin
            errors++;
            $display("FAIL glitch_busy_cycles got %0d expected 1..%0d", busy_cycles, H);
        end
        checks++;
        if (o_busy !== 1'b0 || n_fe != fe0 || n_valid != v0) begin
            errors++;
            $display("FAIL glitch_outputs got busy=%b fe=%0d valid=%0d expected 0 0 0", o_busy, n_fe - fe0,
                     n_valid - v0);
        end
    endtask

    task automatic test_midframe_reset();
        hold_line(1'b0, CPB);
        hold_line(1'b1, 4 * CPB + H);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b expected 1", o_busy);
        end
        do_reset();
        checks++;
        if ({o_data_tdata, o_data_tvalid, o_frame_error, o_err_cnt, o_busy} !== 13'd0) begin
            errors++;
            $display("FAIL midframe_reset_outputs got td=%02h v=%b fe=%b ec=%0d busy=%b expected all 0",
                     o_data_tdata, o_data_tvalid, o_frame_error, o_err_cnt, o_busy);
        end
        hold_line(1'b1, 10 * CPB - (5 * CPB + H) - 1);
        send_byte(8'h12, 1'b1);
        hold_line(1'b1, 2 * CPB);
        check_drained("midframe");
    endtask

    task automatic test_saturation();
        int fe0;
        do_reset();
        fe0 = n_fe;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h0F + 8'(i), 1'b0);
            hold_line(1'b1, CPB);
        end
        check_drained("saturation");
        checks++;
        if (n_fe - fe0 != 5 || o_err_cnt !== 2'd3) begin
            errors++;
            $display("FAIL saturation got fe=%0d cnt=%0d expected 5 3", n_fe - fe0, o_err_cnt);
        end
    endtask

    task automatic test_ubx_frame();
        logic [7:0] pkt[12];
        logic [7:0] ck_a;
        logic [7:0] ck_b;
        logic [7:0] rk_a;
        logic [7:0] rk_b;
        pkt[0] = 8'hB5; pkt[1] = 8'h62; pkt[2] = 8'h01; pkt[3] = 8'h07;
        pkt[4] = 8'h04; pkt[5] = 8'h00; pkt[6] = 8'h11; pkt[7] = 8'h22;
        pkt[8] = 8'h33; pkt[9] = 8'h44;
        ck_a = 8'h00;
        ck_b = 8'h00;
        for (int i = 2; i < 10; i++) begin
            ck_a = ck_a + pkt[i];
            ck_b = ck_b + ck_a;
        end
        pkt[10] = ck_a;
        pkt[11] = ck_b;
        rx_log.delete();
        for (int i = 0; i < 12; i++) begin
            send_byte(pkt[i], 1'b1);
        end
        hold_line(1'b1, 2 * CPB);
        check_drained("ubx");
        checks++;
        if (rx_log.size() != 12) begin
            errors++;
            $display("FAIL ubx_strobes got %0d expected 12", rx_log.size());
        end else begin
            rk_a = 8'h00;
            rk_b = 8'h00;
            for (int i = 2; i < 10; i++) begin
                rk_a = rk_a + rx_log[i];
                rk_b = rk_b + rk_a;
            end
            checks++;
            if (rx_log[10] !== rk_a || rx_log[11] !== rk_b) begin
                errors++;
                $display("FAIL ubx_checksum got %02h %02h expected %02h %02h", rx_log[10], rx_log[11], rk_a,
                         rk_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_midframe_reset();
        test_saturation();
        test_ubx_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ubx_uart_rx.md
# ubx_uart_rx

UART receiver that turns the GNSS module's serial RX line into the byte stream consumed by the UBX packet parser. Sits directly upstream of the parser in the `i_uart_clk` domain. It synchronises the asynchronous line, samples 8N1 frames at mid-bit, and emits one single-cycle `tvalid` strobe per good byte. Framing errors are flagged and counted; the bad byte is never passed on.

## Interface
- `CLKS_PER_BIT`, default 868: `i_uart_clk` cycles per bit. 868 gives 115200 baud at 100 MHz. Legal range is 4 or more.
- `ERR_CNT_W`, default 16: width of the framing-error counter.

- `i_uart_clk`  in  1  system clock; all logic is on its rising edge.
- `i_uart_rst`  in  1  synchronous, active-high reset.
- `i_uart_rxd`  in  1  asynchronous serial line; idles high.
- `o_data_tdata`  out  8  received byte, LSB-first reassembled; valid only while `o_data_tvalid` is high.
- `o_data_tvalid`  out  1  one-cycle strobe per good byte. There is no backpressure.
- `o_frame_error`  out  1  one-cycle strobe when a stop bit is sampled low.
- `o_err_cnt`  out  ERR_CNT_W  saturating count of framing errors.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchroniser**
  - Two flip-flops feed `rx_s`.
  - Both flip-flops reset to 1, so no false start occurs out of reset.
- **Counters**
  - Bit-period counter `cnt` is wide enough to hold `CLKS_PER_BIT-1`.
  - Half-period is H = `CLKS_PER_BIT/2`, integer division.
  - Bit index counts 0..7.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rx_s`=0, go to START with `cnt`=0.
  - **START:**
    - When `cnt`=H-1, sample `rx_s`.
    - If the sample is 0, go to DATA with `cnt`=0 and bit index 0.
    - If the sample is 1, treat it as a glitch and return to IDLE with no output.
    - Otherwise `cnt` increments.
  - **DATA:**
    - When `cnt`=`CLKS_PER_BIT-1`, shift `rx_s` into the MSB of the shift register (right shift, LSB-first line order) and set `cnt`=0.
    - After bit index 7 is sampled, go to STOP.
  - **STOP:** when `cnt`=`CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1: drive `o_data_tdata` with the shift register and pulse `o_data_tvalid`, then go to IDLE.
    - If 0: pulse `o_frame_error` and increment `o_err_cnt`, saturating at all-ones. Go to BREAK. No `tvalid` is generated.
  - **BREAK:** wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing back-to-back false frames.
- **Output data hold:** `o_data_tdata` holds its last value between strobes.
- **Reset values** (from `i_uart_rst`, at any point including mid-frame):
  - FSM returns to IDLE.
  - `cnt`, bit index, shift register, `o_data_tdata` = 0.
  - `o_data_tvalid`, `o_frame_error`, `o_busy` = 0.
  - `o_err_cnt` = 0.
  - Synchroniser = 1.
  - A frame in progress is dropped silently.

## Timing
- Let E be the first clock edge at which `i_uart_rxd` is registered as 0. Then `rx_s`=0 is visible at edge E+2.
- Sample points:
  - Start-bit sample at edge E+2+H.
  - Data bit k (k = 0..7) sampled at edge E+2+H+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at edge E+2+H+9·`CLKS_PER_BIT`.
- Output strobes:
  - `o_data_tvalid` and `o_frame_error` are registered at the stop-sample edge.
  - They are high for exactly the one following cycle.
- `o_err_cnt` updates on the same edge as `o_frame_error`.
- **Back-to-back frames:** after a good stop bit the FSM is in IDLE within 1 cycle. A start bit beginning immediately after the stop-bit period is caught, so `CLKS_PER_BIT` ≥ 4 guarantees no byte loss.
- **Minimum strobe spacing:** 10·`CLKS_PER_BIT` cycles, which satisfies the parser's one-byte-per-strobe requirement.
- **Glitch rejection:** a low pulse shorter than H cycles at the start bit yields no output and no error.
- **Saturation:** at `o_err_cnt` = 2^`ERR_CNT_W`-1, further errors still pulse `o_frame_error`, but the count stays at all-ones.

## Test plan
- `CLKS_PER_BIT`=16, send 0xB5 then 0x62 back-to-back with 8N1.
  - Expect two `o_data_tvalid` pulses carrying 0xB5 then 0x62.
  - Strobes are 160 cycles apart.
  - The first strobe is high in the cycle after edge E+2+8+144.
- Send 0x55 with the stop bit held low, then release the line high, then send 0xA3.
  - Expect one `o_frame_error` pulse and no `tvalid` for 0x55.
  - `o_err_cnt`=1.
  - FSM passes through BREAK.
  - 0xA3 is then received correctly.
- Drive a 5-cycle low glitch on an idle line (`CLKS_PER_BIT`=16).
  - Expect no `tvalid`, no `frame_error`, `o_busy` high for ≤ 8 cycles, and a return to IDLE.
- Assert `i_uart_rst` for 1 cycle during DATA bit 4 of 0xFF, then send 0x12.
  - Expect no output for the aborted byte.
  - All outputs are 0 the cycle after reset.
  - 0x12 is received correctly.
- `ERR_CNT_W`=2, generate 5 framing errors.
  - Expect `o_err_cnt` sequence 1, 2, 3, 3, 3.
  - Expect 5 `o_frame_error` pulses.
- Send a full UBX frame (B5 62 01 07 04 00 11 22 33 44 CK_A CK_B) into the parser via this block.
  - Expect 12 strobes in order.
  - The parser reports no `pkt_error` when the checksum bytes are correct.
